// File: rtl/uart_rx_fifo_if.sv
// Consumer-side port bundle of uart_rx_fifo: head-entry handshake, status and overrun clear.
interface uart_rx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
);
   logic                          rx_valid;
   logic                          rx_ready;
   logic [DATA_BITS-1:0]          rx_data;
   logic                          rx_perr;
   logic                          rx_ferr;
   logic                          rx_overrun;
   logic                          ovr_clr;
   logic [$clog2(FIFO_DEPTH):0]   rx_count;

   modport master (
      output rx_valid, rx_data, rx_perr, rx_ferr, rx_overrun, rx_count,
      input  rx_ready, ovr_clr
   );

   modport slave (
      input  rx_valid, rx_data, rx_perr, rx_ferr, rx_overrun, rx_count,
      output rx_ready, ovr_clr
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Single-clock UART receiver with 16x oversampling, 3-sample majority vote and a
// show-ahead character FIFO carrying per-character parity/framing flags.
module uart_rx_fifo #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           sysclk,
   input  logic           reset,
   input  logic           uart_rx,
   uart_rx_fifo_if.master rx
);
   localparam int DIV = CLK_FREQ / (BAUD * 16);
   localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int IW  = $clog2(DATA_BITS);
   localparam int EW  = DATA_BITS + 2;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_BREAK = 3'd5;

   generate
      if (DIV < 2 || STOP_BITS < 1 || STOP_BITS > 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
          PARITY < 0 || PARITY > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
      begin : g_bad_cfg
         $error("uart_rx_fifo: unsupported parameter set");
      end
   endgenerate

   // ---------------------------------------------------------------- input sync
   logic s1, s2, rxs;

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= uart_rx;
         s2 <= s1;
      end
   end
   assign rxs = s2;

   // ---------------------------------------------------------------- 16x tick
   logic [DW-1:0] div_cnt;
   logic          tick;

   assign tick = (div_cnt == DW'(DIV - 1));

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset)    div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + DW'(1);
   end

   // ---------------------------------------------------------------- receiver FSM
   logic [2:0]           state;
   logic [3:0]           ph, phn;
   logic [1:0]           samp;
   logic [DATA_BITS-1:0] shreg;
   logic [IW-1:0]        idx;
   logic                 perr_q;
   logic                 bitv;
   logic                 push;

   // phn is the phase this tick represents; the start-detect tick itself is phase 0
   assign phn  = ph + 4'd1;
   assign bitv = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
   assign push = tick && (state == S_STOP) && (phn == 4'd9);

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         ph     <= '0;
         samp   <= '0;
         shreg  <= '0;
         idx    <= '0;
         perr_q <= 1'b0;
      end else if (tick) begin
         ph <= phn;
         if (phn == 4'd7 || phn == 4'd8) samp <= {samp[0], rxs};
         case (state)
            S_IDLE: begin
               if (!rxs) begin
                  state  <= S_START;
                  ph     <= '0;
                  shreg  <= '0;
                  perr_q <= 1'b0;
               end
            end
            S_START: begin
               if (phn == 4'd7 && rxs) state <= S_IDLE;
               else if (phn == 4'd15) begin
                  state <= S_DATA;
                  idx   <= '0;
               end
            end
            S_DATA: begin
               if (phn == 4'd9) shreg[idx] <= bitv;
               if (phn == 4'd15) begin
                  if (idx == IW'(DATA_BITS - 1)) state <= (PARITY != 0) ? S_PAR : S_STOP;
                  else                           idx   <= idx + IW'(1);
               end
            end
            S_PAR: begin
               if (phn == 4'd9)  perr_q <= ((^shreg) ^ bitv) != (PARITY == 1);
               if (phn == 4'd15) state  <= S_STOP;
            end
            // Leaving at mid-stop lets the next start edge resync immediately.
            S_STOP: begin
               if (phn == 4'd9) state <= bitv ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
               if (rxs) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [EW-1:0] head;
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count, count_nxt;
   logic          valid_q, ovr_q;
   logic          pop, full, wr_en, ovr_set;

   assign pop       = valid_q && rx.rx_ready;
   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign wr_en     = push && (!full || pop);
   assign ovr_set   = push && full && !pop;
   assign count_nxt = count + (AW+1)'(wr_en) - (AW+1)'(pop);

   always_ff @(posedge sysclk) begin
      if (wr_en) mem[wptr] <= {!bitv, perr_q, shreg};
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         valid_q <= 1'b0;
      end else begin
         if (wr_en) wptr <= wptr + AW'(1);
         if (pop)   rptr <= rptr + AW'(1);
         count   <= count_nxt;
         valid_q <= (count_nxt != '0);
      end
   end

   // A drop in the same cycle as a clear must leave the flag set.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset)          ovr_q <= 1'b0;
      else if (ovr_set)    ovr_q <= 1'b1;
      else if (rx.ovr_clr) ovr_q <= 1'b0;
   end

   assign head          = mem[rptr];
   assign rx.rx_valid   = valid_q;
   assign rx.rx_data    = valid_q ? head[DATA_BITS-1:0] : '0;
   assign rx.rx_perr    = valid_q & head[DATA_BITS];
   assign rx.rx_ferr    = valid_q & head[DATA_BITS+1];
   assign rx.rx_overrun = ovr_q;
   assign rx.rx_count   = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: 8N1 receiver (dut_a) and 8E1 receiver (dut_b), DIV = 10, 160 clk per bit.
module tb_uart_rx_fifo;
   localparam int BT = 160;

   logic sysclk = 1'b0;
   logic reset  = 1'b0;
   logic line_a = 1'b1;
   logic line_b = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 sysclk = ~sysclk;

   uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
   uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifb ();

   uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD(10_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4))
      dut_a (.sysclk(sysclk), .reset(reset), .uart_rx(line_a), .rx(ifa));

   uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD(10_000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4))
      dut_b (.sysclk(sysclk), .reset(reset), .uart_rx(line_b), .rx(ifb));

   task automatic clks(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   // bits[0] goes on the line first
   task automatic send_bits(input int which, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (which == 0) line_a = bits[i];
         else            line_b = bits[i];
         clks(BT);
      end
      line_a = 1'b1;
      line_b = 1'b1;
   endtask

   task automatic send8(input logic [7:0] d);
      send_bits(0, {6'b111111, 1'b1, d, 1'b0}, 10);
   endtask

   task automatic pop_a;
      ifa.rx_ready = 1'b1;
      clks(1);
      ifa.rx_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      clks(3);
      n_chk++;
      if (ifa.rx_valid !== 1'b0 || ifa.rx_data !== 8'h00 || ifa.rx_perr !== 1'b0 ||
          ifa.rx_ferr !== 1'b0 || ifa.rx_overrun !== 1'b0 || ifa.rx_count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b d=%h p=%b f=%b o=%b c=%0d want all 0",
                  ifa.rx_valid, ifa.rx_data, ifa.rx_perr, ifa.rx_ferr, ifa.rx_overrun, ifa.rx_count);
      end
      n_chk++;
      if (ifb.rx_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid_b: got %b want 0", ifb.rx_valid);
      end
      reset = 1'b1;
      clks(5);
   endtask

   // Push lands at the stop-bit centre (153 ticks after the detect tick); sync plus
   // tick phase put the detect tick 3..12 clk after the edge.
   task automatic test_basic_latency;
      int lat;
      lat = -1;
      fork
         send8(8'hA5);
         begin
            for (int i = 0; i < 1700; i++) begin
               @(posedge sysclk); #1;
               if (ifa.rx_valid) begin lat = i + 1; break; end
            end
         end
      join
      n_chk++;
      if (lat < 1528 || lat > 1548) begin
         n_fail++; $display("FAIL latency: got %0d clk want 1528..1548", lat);
      end
      n_chk++;
      if (ifa.rx_valid !== 1'b1 || ifa.rx_data !== 8'hA5 || ifa.rx_perr !== 1'b0 || ifa.rx_ferr !== 1'b0) begin
         n_fail++; $display("FAIL basic_a5: got v=%b d=%h p=%b f=%b want 1 a5 0 0",
                            ifa.rx_valid, ifa.rx_data, ifa.rx_perr, ifa.rx_ferr);
      end
      n_chk++;
      if (ifa.rx_count !== 3'd1) begin
         n_fail++; $display("FAIL basic_count: got %0d want 1", ifa.rx_count);
      end
      pop_a();
      n_chk++;
      if (ifa.rx_valid !== 1'b0 || ifa.rx_count !== 3'd0) begin
         n_fail++; $display("FAIL basic_pop: got v=%b c=%0d want 0 0", ifa.rx_valid, ifa.rx_count);
      end
   endtask

   task automatic test_parity;
      ifb.rx_ready = 1'b0;
      // 0x03 has even weight: even parity wants 0, so a 1 is an error
      send_bits(1, {5'b11111, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
      clks(20);
      n_chk++;
      if (ifb.rx_valid !== 1'b1 || ifb.rx_data !== 8'h03 || ifb.rx_perr !== 1'b1 || ifb.rx_ferr !== 1'b0) begin
         n_fail++; $display("FAIL parity_bad: got v=%b d=%h p=%b f=%b want 1 03 1 0",
                            ifb.rx_valid, ifb.rx_data, ifb.rx_perr, ifb.rx_ferr);
      end
      ifb.rx_ready = 1'b1; clks(1); ifb.rx_ready = 1'b0;
      send_bits(1, {5'b11111, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
      clks(20);
      n_chk++;
      if (ifb.rx_valid !== 1'b1 || ifb.rx_data !== 8'h03 || ifb.rx_perr !== 1'b0) begin
         n_fail++; $display("FAIL parity_good: got v=%b d=%h p=%b want 1 03 0",
                            ifb.rx_valid, ifb.rx_data, ifb.rx_perr);
      end
      // 0x07 has odd weight: parity bit 1 is correct
      ifb.rx_ready = 1'b1; clks(1); ifb.rx_ready = 1'b0;
      send_bits(1, {5'b11111, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
      clks(20);
      n_chk++;
      if (ifb.rx_data !== 8'h07 || ifb.rx_perr !== 1'b0 || ifb.rx_count !== 3'd1) begin
         n_fail++; $display("FAIL parity_odd_weight: got d=%h p=%b c=%0d want 07 0 1",
                            ifb.rx_data, ifb.rx_perr, ifb.rx_count);
      end
      ifb.rx_ready = 1'b1; clks(1); ifb.rx_ready = 1'b0;
   endtask

   task automatic test_glitch;
      line_a = 1'b0; clks(40); line_a = 1'b1;
      clks(3 * BT);
      n_chk++;
      if (ifa.rx_valid !== 1'b0 || ifa.rx_count !== 3'd0) begin
         n_fail++; $display("FAIL false_start: got v=%b c=%0d want 0 0", ifa.rx_valid, ifa.rx_count);
      end
      // 0x00 with a 1-clk high spike in the middle of data bit 2
      line_a = 1'b0; clks(BT + 2 * BT + BT / 2);
      line_a = 1'b1; clks(1);
      line_a = 1'b0; clks(BT / 2 - 1 + 5 * BT);
      line_a = 1'b1; clks(BT + 20);
      n_chk++;
      if (ifa.rx_valid !== 1'b1 || ifa.rx_data !== 8'h00 || ifa.rx_ferr !== 1'b0 || ifa.rx_count !== 3'd1) begin
         n_fail++; $display("FAIL glitch_majority: got v=%b d=%h f=%b c=%0d want 1 00 0 1",
                            ifa.rx_valid, ifa.rx_data, ifa.rx_ferr, ifa.rx_count);
      end
      pop_a();
   endtask

   task automatic test_break;
      line_a = 1'b0; clks(30 * BT);
      line_a = 1'b1; clks(2 * BT);
      n_chk++;
      if (ifa.rx_count !== 3'd1 || ifa.rx_data !== 8'h00 || ifa.rx_ferr !== 1'b1 || ifa.rx_perr !== 1'b0) begin
         n_fail++; $display("FAIL break_entry: got c=%0d d=%h f=%b p=%b want 1 00 1 0",
                            ifa.rx_count, ifa.rx_data, ifa.rx_ferr, ifa.rx_perr);
      end
      pop_a();
      send8(8'h5A);
      clks(20);
      n_chk++;
      if (ifa.rx_count !== 3'd1 || ifa.rx_data !== 8'h5A || ifa.rx_ferr !== 1'b0) begin
         n_fail++; $display("FAIL after_break: got c=%0d d=%h f=%b want 1 5a 0",
                            ifa.rx_count, ifa.rx_data, ifa.rx_ferr);
      end
      pop_a();
   endtask

   task automatic test_overrun;
      logic [7:0] exp;
      ifa.rx_ready = 1'b0;
      for (int i = 0; i < 5; i++) send8(8'h11 + 8'(i));
      clks(20);
      n_chk++;
      if (ifa.rx_count !== 3'd4 || ifa.rx_overrun !== 1'b1) begin
         n_fail++; $display("FAIL full_overrun: got c=%0d o=%b want 4 1", ifa.rx_count, ifa.rx_overrun);
      end
      for (int i = 0; i < 4; i++) begin
         exp = 8'h11 + 8'(i);
         n_chk++;
         if (ifa.rx_valid !== 1'b1 || ifa.rx_data !== exp) begin
            n_fail++; $display("FAIL drain_%0d: got v=%b d=%h want 1 %h", i, ifa.rx_valid, ifa.rx_data, exp);
         end
         pop_a();
      end
      n_chk++;
      if (ifa.rx_valid !== 1'b0 || ifa.rx_count !== 3'd0 || ifa.rx_overrun !== 1'b1) begin
         n_fail++; $display("FAIL drained: got v=%b c=%0d o=%b want 0 0 1",
                            ifa.rx_valid, ifa.rx_count, ifa.rx_overrun);
      end
      ifa.ovr_clr = 1'b1; clks(1); ifa.ovr_clr = 1'b0;
      n_chk++;
      if (ifa.rx_overrun !== 1'b0) begin
         n_fail++; $display("FAIL ovr_clr: got %b want 0", ifa.rx_overrun);
      end
   endtask

   task automatic test_reset_mid_char;
      send8(8'h42);
      clks(20);
      // partial 0x00: stop in the middle of data bit 4
      line_a = 1'b0; clks(BT + 4 * BT + BT / 2);
      reset  = 1'b0; #1;
      line_a = 1'b1;
      n_chk++;
      if (ifa.rx_valid !== 1'b0 || ifa.rx_data !== 8'h00 || ifa.rx_count !== 3'd0 || ifa.rx_overrun !== 1'b0) begin
         n_fail++; $display("FAIL async_reset: got v=%b d=%h c=%0d o=%b want 0 00 0 0",
                            ifa.rx_valid, ifa.rx_data, ifa.rx_count, ifa.rx_overrun);
      end
      clks(3);
      reset = 1'b1;
      clks(2 * BT);
      n_chk++;
      if (ifa.rx_valid !== 1'b0 || ifa.rx_count !== 3'd0) begin
         n_fail++; $display("FAIL no_partial_push: got v=%b c=%0d want 0 0", ifa.rx_valid, ifa.rx_count);
      end
      send8(8'h7E);
      clks(20);
      n_chk++;
      if (ifa.rx_valid !== 1'b1 || ifa.rx_data !== 8'h7E || ifa.rx_ferr !== 1'b0 || ifa.rx_count !== 3'd1) begin
         n_fail++; $display("FAIL after_reset_7e: got v=%b d=%h f=%b c=%0d want 1 7e 0 1",
                            ifa.rx_valid, ifa.rx_data, ifa.rx_ferr, ifa.rx_count);
      end
      pop_a();
   endtask

   initial begin
      ifa.rx_ready = 1'b0;
      ifa.ovr_clr  = 1'b0;
      ifb.rx_ready = 1'b0;
      ifb.ovr_clr  = 1'b0;
      test_reset();
      test_basic_latency();
      test_parity();
      test_glitch();
      test_break();
      test_overrun();
      test_reset_mid_char();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
